// File: rtl/thread_cmd_issue_pkg.sv
// Shared types for the thread command issue block:
// op/response codes, FSM states, FIFO entry layout, legality check.
package thread_cmd_issue_pkg;

    localparam int NTRD  = 8;
    localparam int TRD_W = $clog2(NTRD);
    localparam int PC_W  = 32;

    typedef enum logic [1:0] {
        OP_SPAWN = 2'b00,
        OP_KILL  = 2'b01,
        OP_SLEEP = 2'b10,
        OP_WAKE  = 2'b11
    } trd_op_e;

    typedef enum logic [1:0] {
        RSP_OK        = 2'b00,
        RSP_OVERFLOW  = 2'b01,
        RSP_NOT_CHILD = 2'b10,
        RSP_NOT_VALID = 2'b11
    } rsp_code_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } issue_state_e;

    typedef struct packed {
        trd_op_e          op;
        logic [TRD_W-1:0] act;
        logic [TRD_W-1:0] obj;
        logic [PC_W-1:0]  pc;
    } cmd_entry_t;

    // Self-targeted KILL/SLEEP is legal; SPAWN ignores obj.
    function automatic rsp_code_e legal_code(
        input cmd_entry_t      e,
        input logic [NTRD-1:0] vld,
        input logic [NTRD-1:0] chd
    );
        rsp_code_e c;
        c = RSP_OK;
        case (e.op)
            OP_SPAWN: begin
                if (&vld) c = RSP_OVERFLOW;
            end
            OP_KILL, OP_SLEEP: begin
                if (!vld[e.obj])
                    c = RSP_NOT_VALID;
                else if (e.obj != e.act && !chd[e.obj])
                    c = RSP_NOT_CHILD;
            end
            default: begin
                if (!vld[e.obj]) c = RSP_NOT_VALID;
            end
        endcase
        return c;
    endfunction

endpackage

// File: rtl/thread_cmd_issue_if.sv
// EX-side request and writeback-side response bundle
// of the thread command issue block.
interface thread_cmd_issue_if;
    import thread_cmd_issue_pkg::*;

    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_op;
    logic [TRD_W-1:0] req_act;
    logic [TRD_W-1:0] req_obj;
    logic [PC_W-1:0]  req_pc;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [1:0]       rsp_code;
    logic [TRD_W-1:0] rsp_trd;

    modport master (
        output req_valid, req_op, req_act, req_obj, req_pc, rsp_ready,
        input  req_ready, rsp_valid, rsp_code, rsp_trd
    );

    modport slave (
        input  req_valid, req_op, req_act, req_obj, req_pc, rsp_ready,
        output req_ready, rsp_valid, rsp_code, rsp_trd
    );

endinterface

// File: rtl/thread_cmd_issue_fifo.sv
// Small synchronous FIFO of decoded thread commands.
// Head entry is visible combinationally on dout.
module thread_cmd_issue_fifo
    import thread_cmd_issue_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  cmd_entry_t                 din,
    input  logic                       pop,
    output cmd_entry_t                 dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    cmd_entry_t       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign dout  = mem[rd_ptr];

    // Storage, pointers (wrap mod DEPTH) and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                count <= count + CNT_W'(1);
            else if (pop && !push)
                count <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/thread_cmd_issue.sv
// Buffers EX thread ops, legality-checks them against thread_ctrl
// status, pulses one command per op and returns a registered response.
module thread_cmd_issue
    import thread_cmd_issue_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int NTRD  = thread_cmd_issue_pkg::NTRD,
    parameter int TRD_W = thread_cmd_issue_pkg::TRD_W,
    parameter int PC_W  = thread_cmd_issue_pkg::PC_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    thread_cmd_issue_if.slave       bus,
    input  logic                    ctrl_stall,
    input  logic [NTRD-1:0]         valid_trd,
    input  logic [NTRD-1:0]         child_trd,
    input  logic [TRD_W-1:0]        new_trd,
    output logic                    cmd_init,
    output logic                    cmd_kill,
    output logic                    cmd_slp,
    output logic                    cmd_wake,
    output logic [TRD_W-1:0]        cmd_act_trd,
    output logic [TRD_W-1:0]        cmd_obj_trd,
    output logic [PC_W-1:0]         cmd_pc,
    output logic                    busy
);

    issue_state_e               state;
    cmd_entry_t                 head;
    cmd_entry_t                 din;
    logic                       full;
    logic                       empty;
    logic [$clog2(DEPTH+1)-1:0] count;
    logic                       push;
    logic                       pop;
    rsp_code_e                  code;
    trd_op_e                    op_q;
    logic                       rsp_valid_q;
    rsp_code_e                  rsp_code_q;
    logic [TRD_W-1:0]           rsp_trd_q;

    assign push = bus.req_valid && !full;
    assign din  = '{op:  trd_op_e'(bus.req_op),
                    act: bus.req_act,
                    obj: bus.req_obj,
                    pc:  bus.req_pc};

    thread_cmd_issue_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (din),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    assign code = legal_code(head, valid_trd, child_trd);
    assign pop  = (state == S_ISSUE) ||
                  (state == S_CHECK && code != RSP_OK);

    assign bus.req_ready = !full;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_code  = rsp_code_q;
    assign bus.rsp_trd   = rsp_trd_q;

    assign cmd_act_trd = empty ? '0 : head.act;
    assign cmd_obj_trd = empty ? '0 : head.obj;
    assign cmd_pc      = empty ? '0 : head.pc;
    assign busy        = (count != '0) || (state != S_IDLE);

    // Issue FSM with registered command pulses and response fields.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cmd_init    <= 1'b0;
            cmd_kill    <= 1'b0;
            cmd_slp     <= 1'b0;
            cmd_wake    <= 1'b0;
            op_q        <= OP_SPAWN;
            rsp_valid_q <= 1'b0;
            rsp_code_q  <= RSP_OK;
            rsp_trd_q   <= '0;
        end else begin
            cmd_init <= 1'b0;
            cmd_kill <= 1'b0;
            cmd_slp  <= 1'b0;
            cmd_wake <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (!empty || push) state <= S_CHECK;
                end
                S_CHECK: begin
                    if (code != RSP_OK) begin
                        rsp_code_q  <= code;
                        rsp_trd_q   <= head.obj;
                        rsp_valid_q <= 1'b1;
                        state       <= S_RESP;
                    end else if (!ctrl_stall) begin
                        op_q      <= head.op;
                        rsp_trd_q <= head.obj;
                        unique case (1'b1)
                            (head.op == OP_SPAWN): cmd_init <= 1'b1;
                            (head.op == OP_KILL):  cmd_kill <= 1'b1;
                            (head.op == OP_SLEEP): cmd_slp  <= 1'b1;
                            (head.op == OP_WAKE):  cmd_wake <= 1'b1;
                        endcase
                        state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (op_q == OP_SPAWN) rsp_trd_q <= new_trd;
                    rsp_code_q  <= RSP_OK;
                    rsp_valid_q <= 1'b1;
                    state       <= S_RESP;
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state <= (!empty || push) ? S_CHECK : S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
